// File: rtl/mem_access.sv
// mem_access: MEM-stage data-memory access unit.
//   Turns one load/store command from EX into a single req/ack bus transaction on a 64-bit,
//   doubleword-aligned data bus, stalling the pipeline until the bus acknowledges.
//   Sub-doubleword accesses use byte lanes; loads are sign- or zero-extended.
// Ports:
//   clk, rst                      clock / asynchronous active-high reset
//   MemRead, MemWrite             load / store command
//   MemSize, MemSext              00 byte, 01 half, 10 word, 11 dword; sign-extend loads
//   addr, w_data                  byte address and right-justified store data
//   stall                         hold upstream stages and command inputs
//   rd_data, rd_valid             extended load result (registered) and its 1-cycle valid pulse
//   mem_err                       1-cycle pulse: misaligned access or read+write together
//   bus_req/we/addr/wdata/wstrb   bus request side, held stable until bus_ack
//   bus_rdata, bus_ack            bus response side
module mem_access #(
  parameter int unsigned WORD   = 64,
  parameter int unsigned STRB_W = WORD / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        MemSize,
  input  logic              MemSext,
  input  logic [WORD-1:0]   addr,
  input  logic [WORD-1:0]   w_data,
  output logic              stall,
  output logic [WORD-1:0]   rd_data,
  output logic              rd_valid,
  output logic              mem_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [WORD-1:0]   bus_addr,
  output logic [WORD-1:0]   bus_wdata,
  output logic [STRB_W-1:0] bus_wstrb,
  input  logic [WORD-1:0]   bus_rdata,
  input  logic              bus_ack
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        r_state;
  logic [2:0]        r_off;
  logic [1:0]        r_size;
  logic              r_sext;
  logic              r_we;
  logic [WORD-1:0]   r_bus_addr;
  logic [WORD-1:0]   r_bus_wdata;
  logic [STRB_W-1:0] r_bus_wstrb;
  logic [WORD-1:0]   r_rd_data;
  logic              r_rd_valid;
  logic              r_mem_err;

  logic              w_cmd;
  logic              w_both;
  logic [2:0]        w_low_mask;
  logic [STRB_W-1:0] w_lane_mask;
  logic              w_aligned;
  logic              w_start;
  logic              w_bad;
  logic [WORD-1:0]   w_shift;
  logic [WORD-1:0]   w_load;

  assign w_cmd  = MemRead ^ MemWrite;
  assign w_both = MemRead & MemWrite;

  // Low-address mask (size_bytes-1) and byte-lane mask per access size.
  always_comb begin
    w_low_mask  = 3'd0;
    w_lane_mask = 8'h01;
    unique case (MemSize)
      2'b00: begin w_low_mask = 3'd0; w_lane_mask = 8'h01; end
      2'b01: begin w_low_mask = 3'd1; w_lane_mask = 8'h03; end
      2'b10: begin w_low_mask = 3'd3; w_lane_mask = 8'h0F; end
      2'b11: begin w_low_mask = 3'd7; w_lane_mask = 8'hFF; end
      default: ;
    endcase
  end

  assign w_aligned = (addr[2:0] & w_low_mask) == 3'd0;
  assign w_start   = (r_state == IDLE) && w_cmd && w_aligned;
  assign w_bad     = (r_state == IDLE) && (w_both || (w_cmd && !w_aligned));

  // Stall the cycle the command is accepted and every cycle waiting for ack.
  assign stall = w_start || (r_state == REQ);

  // Move the addressed lane down to bit 0, then truncate and extend.
  assign w_shift = bus_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load = w_shift;
    unique case (r_size)
      2'b00: w_load = {{(WORD-8){r_sext & w_shift[7]}}, w_shift[7:0]};
      2'b01: w_load = {{(WORD-16){r_sext & w_shift[15]}}, w_shift[15:0]};
      2'b10: w_load = {{(WORD-32){r_sext & w_shift[31]}}, w_shift[31:0]};
      2'b11: w_load = w_shift;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_off       <= 3'd0;
      r_size      <= 2'd0;
      r_sext      <= 1'b0;
      r_we        <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_mem_err   <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_mem_err  <= w_bad;
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_off       <= addr[2:0];
            r_size      <= MemSize;
            r_sext      <= MemSext;
            r_we        <= MemWrite;
            r_bus_addr  <= {addr[WORD-1:3], 3'b000};
            r_bus_wdata <= w_data << {addr[2:0], 3'b000};
            r_bus_wstrb <= MemWrite ? (w_lane_mask << addr[2:0]) : '0;
            r_state     <= REQ;
          end
        end
        REQ: begin
          if (bus_ack) begin
            r_state <= RESP;
            if (!r_we) begin
              r_rd_data  <= w_load;
              r_rd_valid <= 1'b1;
            end
          end
        end
        RESP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus_req   = (r_state == REQ);
  assign bus_we    = r_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_wstrb = r_bus_wstrb;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign mem_err   = r_mem_err;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemSize;
  logic        MemSext;
  logic [63:0] addr;
  logic [63:0] w_data;
  logic        stall;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        mem_err;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic [63:0] bus_rdata;
  logic        bus_ack;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access dut (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .MemSize   (MemSize),
    .MemSext   (MemSext),
    .addr      (addr),
    .w_data    (w_data),
    .stall     (stall),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .mem_err   (mem_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wstrb (bus_wstrb),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a command at the current negedge; it is sampled on the next posedge.
  task automatic cmd(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                     input logic [63:0] a, input logic [63:0] d);
    MemRead  = rd;
    MemWrite = wr;
    MemSize  = sz;
    MemSext  = sx;
    addr     = a;
    w_data   = d;
  endtask

  task automatic idle_cmd();
    cmd(1'b0, 1'b0, 2'b00, 1'b0, 64'h0, 64'h0);
  endtask

  initial begin
    rst       = 1'b1;
    bus_ack   = 1'b0;
    bus_rdata = 64'h0;
    idle_cmd();
    #3;
    chk("rst_bus_req", {63'b0, bus_req}, 64'd0);
    chk("rst_stall", {63'b0, stall}, 64'd0);
    chk("rst_rd_data", rd_data, 64'h0);
    chk("rst_rd_valid", {63'b0, rd_valid}, 64'd0);
    chk("rst_mem_err", {63'b0, mem_err}, 64'd0);
    chk("rst_wstrb", {56'b0, bus_wstrb}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle with ack toggling: nothing should move.
    for (int i = 0; i < 4; i++) begin
      bus_ack = ~bus_ack;
      @(negedge clk);
      chk("idle_bus_req", {63'b0, bus_req}, 64'd0);
      chk("idle_stall", {63'b0, stall}, 64'd0);
      chk("idle_rd_valid", {63'b0, rd_valid}, 64'd0);
    end
    bus_ack = 1'b0;

    // STUR dword 0x100, ack on third REQ cycle: four stall cycles.
    cmd(1'b0, 1'b1, 2'b11, 1'b0, 64'h100, 64'h1122334455667788);
    #1 chk("st_stall_cmd", {63'b0, stall}, 64'd1);
    @(negedge clk);
    idle_cmd();
    #1;
    chk("st_bus_req", {63'b0, bus_req}, 64'd1);
    chk("st_bus_we", {63'b0, bus_we}, 64'd1);
    chk("st_bus_addr", bus_addr, 64'h100);
    chk("st_wstrb", {56'b0, bus_wstrb}, 64'hFF);
    chk("st_wdata", bus_wdata, 64'h1122334455667788);
    chk("st_stall_req1", {63'b0, stall}, 64'd1);
    @(negedge clk);
    chk("st_stall_req2", {63'b0, stall}, 64'd1);
    chk("st_addr_hold", bus_addr, 64'h100);
    @(negedge clk);
    chk("st_stall_req3", {63'b0, stall}, 64'd1);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("st_resp_stall", {63'b0, stall}, 64'd0);
    chk("st_resp_req", {63'b0, bus_req}, 64'd0);
    chk("st_resp_rd_valid", {63'b0, rd_valid}, 64'd0);
    chk("st_rd_data_kept", rd_data, 64'h0);
    @(negedge clk);

    // LDURB sign-extended from lane 7.
    cmd(1'b1, 1'b0, 2'b00, 1'b1, 64'h107, 64'h0);
    @(negedge clk);
    idle_cmd();
    #1;
    chk("ldb_bus_req", {63'b0, bus_req}, 64'd1);
    chk("ldb_bus_we", {63'b0, bus_we}, 64'd0);
    chk("ldb_bus_addr", bus_addr, 64'h100);
    chk("ldb_wstrb", {56'b0, bus_wstrb}, 64'h00);
    bus_ack   = 1'b1;
    bus_rdata = 64'h80AA_BBCC_DDEE_FF11;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("ldb_rd_data", rd_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("ldb_rd_valid", {63'b0, rd_valid}, 64'd1);
    chk("ldb_resp_stall", {63'b0, stall}, 64'd0);
    @(negedge clk);
    chk("ldb_rd_valid_pulse", {63'b0, rd_valid}, 64'd0);
    chk("ldb_rd_data_hold", rd_data, 64'hFFFF_FFFF_FFFF_FF80);

    // LDURH zero-extended at offset 2, zero-wait ack.
    cmd(1'b1, 1'b0, 2'b01, 1'b0, 64'h0A, 64'h0);
    @(negedge clk);
    idle_cmd();
    chk("ldh_bus_addr", bus_addr, 64'h08);
    bus_ack   = 1'b1;
    bus_rdata = 64'h1234_5678_BEEF_9ABC;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("ldh_rd_data", rd_data, 64'h0000_0000_0000_BEEF);
    chk("ldh_rd_valid", {63'b0, rd_valid}, 64'd1);
    @(negedge clk);

    // LDURSW aligned at offset 4, sign-extended.
    cmd(1'b1, 1'b0, 2'b10, 1'b1, 64'h104, 64'h0);
    @(negedge clk);
    idle_cmd();
    bus_ack   = 1'b1;
    bus_rdata = 64'h8000_0001_7777_7777;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("ldsw_rd_data", rd_data, 64'hFFFF_FFFF_8000_0001);
    @(negedge clk);

    // Store must leave rd_data alone.
    cmd(1'b0, 1'b1, 2'b11, 1'b0, 64'h200, 64'h5555);
    @(negedge clk);
    idle_cmd();
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("st2_rd_data_kept", rd_data, 64'hFFFF_FFFF_8000_0001);
    chk("st2_rd_valid", {63'b0, rd_valid}, 64'd0);
    @(negedge clk);

    // Misaligned LDURSW: no bus cycle, mem_err pulse.
    cmd(1'b1, 1'b0, 2'b10, 1'b1, 64'h102, 64'h0);
    #1 chk("mis_stall", {63'b0, stall}, 64'd0);
    @(negedge clk);
    idle_cmd();
    chk("mis_mem_err", {63'b0, mem_err}, 64'd1);
    chk("mis_bus_req", {63'b0, bus_req}, 64'd0);
    @(negedge clk);
    chk("mis_mem_err_pulse", {63'b0, mem_err}, 64'd0);

    // MemRead & MemWrite together.
    cmd(1'b1, 1'b1, 2'b11, 1'b0, 64'h100, 64'h0);
    #1 chk("rw_stall", {63'b0, stall}, 64'd0);
    @(negedge clk);
    idle_cmd();
    chk("rw_mem_err", {63'b0, mem_err}, 64'd1);
    chk("rw_bus_req", {63'b0, bus_req}, 64'd0);
    @(negedge clk);

    // STURH at 0x06, then asynchronous reset mid-REQ.
    cmd(1'b0, 1'b1, 2'b01, 1'b0, 64'h06, 64'hAAAA_BBBB_CCCC_1234);
    @(negedge clk);
    idle_cmd();
    chk("sth_bus_req", {63'b0, bus_req}, 64'd1);
    chk("sth_wstrb", {56'b0, bus_wstrb}, 64'hC0);
    chk("sth_wdata", bus_wdata, 64'h1234_0000_0000_0000);
    chk("sth_bus_addr", bus_addr, 64'h0);
    #2 rst = 1'b1;
    #1;
    chk("arst_bus_req", {63'b0, bus_req}, 64'd0);
    chk("arst_stall", {63'b0, stall}, 64'd0);
    chk("arst_wstrb", {56'b0, bus_wstrb}, 64'h00);
    chk("arst_rd_data", rd_data, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("arst_rd_valid", {63'b0, rd_valid}, 64'd0);
    chk("arst_mem_err", {63'b0, mem_err}, 64'd0);

    // Next load after reset completes normally.
    cmd(1'b1, 1'b0, 2'b11, 1'b0, 64'h18, 64'h0);
    @(negedge clk);
    idle_cmd();
    chk("ldd_bus_addr", bus_addr, 64'h18);
    bus_ack   = 1'b1;
    bus_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("ldd_rd_data", rd_data, 64'hDEAD_BEEF_CAFE_F00D);
    chk("ldd_rd_valid", {63'b0, rd_valid}, 64'd1);
    @(negedge clk);
    chk("ldd_back_idle", {63'b0, bus_req}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
